// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register: valid/ready handshake, 2-entry skid buffer,
// legacy freeze hold and a synchronous flush that squashes in-flight entries.
module exe_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] ST_val_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] ST_val,
    output logic [DEST_W-1:0] Dest,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              r_state;

    logic                r_m_wb, r_m_mr, r_m_mw;
    logic [DATA_W-1:0]   r_m_alu, r_m_st;
    logic [DEST_W-1:0]   r_m_dest;

    logic                r_s_wb, r_s_mr, r_s_mw;
    logic [DATA_W-1:0]   r_s_alu, r_s_st;
    logic [DEST_W-1:0]   r_s_dest;

    logic                w_accept;
    logic                w_pop;

    assign in_ready  = ~freeze & ~flush & (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready & ~freeze;

    assign count      = r_state;
    assign WB_EN      = r_m_wb;
    assign MEM_R_EN   = r_m_mr;
    assign MEM_W_EN   = r_m_mw;
    assign ALU_result = r_m_alu;
    assign ST_val     = r_m_st;
    assign Dest       = r_m_dest;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_m_wb   <= 1'b0;
            r_m_mr   <= 1'b0;
            r_m_mw   <= 1'b0;
            r_m_alu  <= '0;
            r_m_st   <= '0;
            r_m_dest <= '0;
            r_s_wb   <= 1'b0;
            r_s_mr   <= 1'b0;
            r_s_mw   <= 1'b0;
            r_s_alu  <= '0;
            r_s_st   <= '0;
            r_s_dest <= '0;
        end else if (flush) begin
            // Squash: only control bits are cleared, datapath fields keep their values.
            r_state <= EMPTY;
            r_m_wb  <= 1'b0;
            r_m_mr  <= 1'b0;
            r_m_mw  <= 1'b0;
            r_s_wb  <= 1'b0;
            r_s_mr  <= 1'b0;
            r_s_mw  <= 1'b0;
        end else if (!freeze) begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_m_wb   <= WB_EN_in;
                        r_m_mr   <= MEM_R_EN_in;
                        r_m_mw   <= MEM_W_EN_in;
                        r_m_alu  <= ALU_result_in;
                        r_m_st   <= ST_val_in;
                        r_m_dest <= Dest_in;
                        r_state  <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        r_m_wb   <= WB_EN_in;
                        r_m_mr   <= MEM_R_EN_in;
                        r_m_mw   <= MEM_W_EN_in;
                        r_m_alu  <= ALU_result_in;
                        r_m_st   <= ST_val_in;
                        r_m_dest <= Dest_in;
                    end else if (w_accept) begin
                        r_s_wb   <= WB_EN_in;
                        r_s_mr   <= MEM_R_EN_in;
                        r_s_mw   <= MEM_W_EN_in;
                        r_s_alu  <= ALU_result_in;
                        r_s_st   <= ST_val_in;
                        r_s_dest <= Dest_in;
                        r_state  <= FULL;
                    end else if (w_pop) begin
                        r_m_wb  <= 1'b0;
                        r_m_mr  <= 1'b0;
                        r_m_mw  <= 1'b0;
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_m_wb   <= r_s_wb;
                        r_m_mr   <= r_s_mr;
                        r_m_mw   <= r_s_mw;
                        r_m_alu  <= r_s_alu;
                        r_m_st   <= r_s_st;
                        r_m_dest <= r_s_dest;
                        r_state  <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench: default-width and 64/5-width instances share control stimulus;
// the narrow instance sees the low slices of the wide data.
module tb_exe_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, in_valid, out_ready;
    logic        wb_in, mr_in, mw_in;
    logic [63:0] d_alu, d_st;
    logic [4:0]  d_dest;

    logic        rdy0, vld0, wb0, mr0, mw0;
    logic [31:0] alu0, st0;
    logic [3:0]  dest0;
    logic [1:0]  cnt0;

    logic        rdy1, vld1, wb1, mr1, mw1;
    logic [63:0] alu1, st1;
    logic [4:0]  dest1;
    logic [1:0]  cnt1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(4)) dut0 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0),
        .WB_EN_in(wb_in), .MEM_R_EN_in(mr_in), .MEM_W_EN_in(mw_in),
        .ALU_result_in(d_alu[31:0]), .ST_val_in(d_st[31:0]), .Dest_in(d_dest[3:0]),
        .out_valid(vld0), .out_ready(out_ready),
        .WB_EN(wb0), .MEM_R_EN(mr0), .MEM_W_EN(mw0),
        .ALU_result(alu0), .ST_val(st0), .Dest(dest0), .count(cnt0)
    );

    exe_mem_pipe_reg #(.DATA_W(64), .DEST_W(5)) dut1 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1),
        .WB_EN_in(wb_in), .MEM_R_EN_in(mr_in), .MEM_W_EN_in(mw_in),
        .ALU_result_in(d_alu), .ST_val_in(d_st), .Dest_in(d_dest),
        .out_valid(vld1), .out_ready(out_ready),
        .WB_EN(wb1), .MEM_R_EN(mr1), .MEM_W_EN(mw1),
        .ALU_result(alu1), .ST_val(st1), .Dest(dest1), .count(cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] cnt,
                             input logic [63:0] alu, input logic [63:0] st,
                             input logic [4:0] dest,
                             input logic wb, input logic mr, input logic mw);
        logic [31:0] alu_lo, st_lo;
        logic [3:0]  dest_lo;
        alu_lo  = alu[31:0];
        st_lo   = st[31:0];
        dest_lo = dest[3:0];
        chk({tag, ".cnt0"},  {62'd0, cnt0}, {62'd0, cnt});
        chk({tag, ".vld0"},  {63'd0, vld0}, {63'd0, (cnt != 2'd0)});
        chk({tag, ".alu0"},  {32'd0, alu0}, {32'd0, alu_lo});
        chk({tag, ".st0"},   {32'd0, st0},  {32'd0, st_lo});
        chk({tag, ".dest0"}, {60'd0, dest0}, {60'd0, dest_lo});
        chk({tag, ".ctl0"},  {61'd0, wb0, mr0, mw0}, {61'd0, wb, mr, mw});
        chk({tag, ".cnt1"},  {62'd0, cnt1}, {62'd0, cnt});
        chk({tag, ".vld1"},  {63'd0, vld1}, {63'd0, (cnt != 2'd0)});
        chk({tag, ".alu1"},  alu1, alu);
        chk({tag, ".st1"},   st1,  st);
        chk({tag, ".dest1"}, {59'd0, dest1}, {59'd0, dest});
        chk({tag, ".ctl1"},  {61'd0, wb1, mr1, mw1}, {61'd0, wb, mr, mw});
    endtask

    task automatic chk_rdy(input string tag, input logic exp);
        chk({tag, ".rdy0"}, {63'd0, rdy0}, {63'd0, exp});
        chk({tag, ".rdy1"}, {63'd0, rdy1}, {63'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        wb_in = 1'b0; mr_in = 1'b0; mw_in = 1'b0;
        d_alu = '0; d_st = '0; d_dest = '0;
        #12 rst = 1'b0;
        #1;
        chk_state("reset", 2'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_rdy("reset", 1'b1);

        // Streaming: one per cycle, count stays at one
        in_valid = 1'b1; out_ready = 1'b1; wb_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d_alu = 64'(i); d_st = 64'(i * 16); d_dest = 5'(i);
            #1 chk_rdy("stream", 1'b1);
            tick;
            chk_state("stream", 2'd1, 64'(i), 64'(i * 16), 5'(i), 1'b1, 1'b0, 1'b0);
        end
        in_valid = 1'b0; wb_in = 1'b0;
        tick;
        chk_state("stream_drain", 2'd0, 64'd4, 64'd64, 5'd4, 1'b0, 1'b0, 1'b0);

        // Backpressure into the skid entry
        in_valid = 1'b1; d_alu = 64'hA; d_st = 64'h1A; d_dest = 5'd3; wb_in = 1'b1;
        tick;
        chk_state("bp_a", 2'd1, 64'hA, 64'h1A, 5'd3, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0; d_alu = ONES; d_st = ONES; d_dest = 5'd31; mr_in = 1'b1;
        #1 chk_rdy("bp_one", 1'b1);
        tick;
        chk_state("bp_full", 2'd2, 64'hA, 64'h1A, 5'd3, 1'b1, 1'b0, 1'b0);
        chk_rdy("bp_full", 1'b0);
        d_alu = 64'hC; d_st = 64'h1C; d_dest = 5'd2; mr_in = 1'b0;
        tick;
        chk_state("bp_hold", 2'd2, 64'hA, 64'h1A, 5'd3, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0; wb_in = 1'b0; out_ready = 1'b1;
        tick;
        chk_state("bp_b", 2'd1, ONES, ONES, 5'd31, 1'b1, 1'b1, 1'b0);
        chk_rdy("bp_b", 1'b1);
        tick;
        chk_state("bp_drain", 2'd0, ONES, ONES, 5'd31, 1'b0, 1'b0, 1'b0);

        // Freeze holds everything, even with out_ready=1
        in_valid = 1'b1; d_alu = 64'h55; d_st = 64'h155; d_dest = 5'd5;
        wb_in = 1'b1; mw_in = 1'b1;
        tick;
        chk_state("frz_load", 2'd1, 64'h55, 64'h155, 5'd5, 1'b1, 1'b0, 1'b1);
        freeze = 1'b1; d_alu = 64'h66; d_st = 64'h166; d_dest = 5'd7; wb_in = 1'b0;
        #1 chk_rdy("frz", 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_state("frz_hold", 2'd1, 64'h55, 64'h155, 5'd5, 1'b1, 1'b0, 1'b1);
            chk_rdy("frz_hold", 1'b0);
        end

        // Fill to two, then flush together with freeze
        freeze = 1'b0; out_ready = 1'b0; d_alu = 64'h77; d_st = 64'h177; d_dest = 5'd9;
        wb_in = 1'b1; mw_in = 1'b1;
        tick;
        chk_state("fl_full", 2'd2, 64'h55, 64'h155, 5'd5, 1'b1, 1'b0, 1'b1);
        flush = 1'b1; freeze = 1'b1; d_alu = 64'h88;
        #1 chk_rdy("fl", 1'b0);
        tick;
        chk_state("fl_done", 2'd0, 64'h55, 64'h155, 5'd5, 1'b0, 1'b0, 1'b0);
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
        tick;
        chk_state("fl_idle", 2'd0, 64'h55, 64'h155, 5'd5, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset with two entries held
        in_valid = 1'b1; out_ready = 1'b0; d_alu = 64'h91; d_st = 64'h191; d_dest = 5'd1;
        wb_in = 1'b1; mr_in = 1'b1; mw_in = 1'b0;
        tick;
        d_alu = 64'h92;
        tick;
        chk_state("rst_pre", 2'd2, 64'h91, 64'h191, 5'd1, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_state("rst_async", 2'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_rdy("rst_async", 1'b1);
        #1 rst = 1'b0;
        tick;
        chk_state("rst_after", 2'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_mem_pipe_reg.md
# exe_mem_pipe_reg

Parametrised EXE→MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer. It sits between the execute stage and the memory stage. It carries the write-back/memory control bits, the ALU result, the store value and the destination register. It keeps the legacy freeze (stall) behaviour and adds per-entry valid tracking, backpressure and a synchronous flush that squashes in-flight instructions.

## Interface
- DATA_W, 32, width of ALU result and store value
- DEST_W, 4, width of destination register index
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  hold all state; no accept, no pop
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block accepts this cycle
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control bits
- ALU_result_in, ST_val_in  in  DATA_W each  datapath values
- Dest_in  in  DEST_W  destination index
- out_valid  out  1  output entry valid
- out_ready  in  1  memory stage consumes this cycle
- WB_EN, MEM_R_EN, MEM_W_EN  out  1 each  registered control of head entry
- ALU_result, ST_val  out  DATA_W each  registered head data
- Dest  out  DEST_W  registered head destination
- count  out  2  occupancy, 0..2

## Operation
- Two entries: main (drives outputs) and skid. State is count: EMPTY=0, ONE=1, FULL=2.
- accept = in_valid & in_ready. pop = out_valid & out_ready & ~freeze.
- in_ready = ~freeze & ~flush & (count != 2). This is combinational from inputs and registered count.
- out_valid = (count != 0).
- Transitions (no flush, no freeze):
  - EMPTY: accept -> main<=in, ONE.
  - ONE: accept&pop -> main<=in, stays ONE. accept&~pop -> skid<=in, FULL. pop&~accept -> EMPTY.
  - FULL: pop -> main<=skid, ONE. Accept is impossible (in_ready=0).
- Flush: count<=0. Control bits of main and skid are cleared. Data fields hold their value. Flush has priority over freeze, accept and pop.
- Freeze (no flush): every register holds and in_ready=0. Outputs stay stable. Pop is suppressed even if out_ready=1.
- Stale enables:
  - Whenever main becomes empty (pop to EMPTY, or flush), main's WB_EN/MEM_R_EN/MEM_W_EN are cleared to 0.
  - Therefore WB_EN=MEM_R_EN=MEM_W_EN=0 whenever out_valid=0.
- Data is carried unmodified; no arithmetic. Order is strictly FIFO.

## Timing
- Reset (async, immediate): all outputs 0, count=0, out_valid=0. in_ready=1 while freeze=flush=0.
- Latency: 1 cycle from accept to out_valid/outputs.
- Throughput: one instruction per cycle with out_ready held 1 (ONE state, accept&pop).
- out_ready deasserting absorbs exactly one further instruction into skid. in_ready drops the following cycle.
- out_ready reasserting in FULL: skid moves to main on that edge. in_ready=1 the next cycle. No bubble and no loss.
- Outputs change only on clock edges or reset. in_ready is the only combinational output.
- Reset mid-operation discards both entries. There is no recovery of in-flight data.

## Test plan
- Reset with entries held -> all outputs 0, count=0, in_ready=1 immediately, without waiting for a clock edge.
- Streaming:
  - Stimulus: in_valid=1, out_ready=1, ALU_result_in=1,2,3,4 on consecutive cycles.
  - Required: outputs 1,2,3,4 on cycles +1..+4, count=1 throughout, in_ready=1 every cycle.
- Backpressure:
  - Stimulus: accept A=0xA, then hold out_ready=0 and present B=0xB.
  - Required: count=2, in_ready=0, outputs hold A.
  - Then out_ready=1 for two cycles: A then B, count returns to 0, WB_EN=0 after drain.
- Freeze:
  - Stimulus: count=1, WB_EN=1, Dest=5; freeze=1 for 3 cycles with out_ready=1 and in_valid=1.
  - Required: outputs and count unchanged, in_ready=0, no pop.
- Flush:
  - Stimulus: count=2, MEM_W_EN=1; flush=1 together with freeze=1 and in_valid=1.
  - Required: next cycle count=0, out_valid=0, WB_EN=MEM_R_EN=MEM_W_EN=0, input not accepted.
- Parameter sweep: DATA_W=64, DEST_W=5 run through the streaming and backpressure scenarios -> full-width values 0xFFFF_FFFF_FFFF_FFFF and Dest=31 pass through intact.
